// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time and hands instructions to decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_killed event counters.
module fetch_sequencer #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_killed
`endif
);

  localparam int unsigned PERF_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic                   r_kill;
  logic                   w_kill_nxt;
  logic [PC_WIDTH-1:0]    r_if_pc;
  logic [PC_WIDTH-1:0]    w_if_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_if_instr;
  logic [INSTR_WIDTH-1:0] w_if_instr_nxt;

  // State and datapath registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  // Next-state: r_kill marks the in-flight request as stale so its response gets dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (imem_req_ready) begin
          w_state_nxt = ST_WAIT;
          w_kill_nxt  = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_kill || redirect_valid) begin
            if (redirect_valid) w_pc_nxt = redirect_pc;
            w_kill_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_if_pc_nxt    = r_pc;
            w_if_instr_nxt = imem_rsp_data;
            w_state_nxt    = ST_HOLD;
          end
        end else if (redirect_valid) begin
          w_pc_nxt   = redirect_pc;
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_REQ;
        end else if (if_ready) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = (r_state == ST_HOLD);
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign pc             = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic                  w_fetch_hs;
  logic                  w_drop;
  logic [PERF_WIDTH-1:0] r_perf_fetched;
  logic [PERF_WIDTH-1:0] r_perf_killed;

  // A kill is a dropped response or a presented instruction discarded without handshake.
  assign w_fetch_hs = (r_state == ST_HOLD) && if_ready;
  assign w_drop     = ((r_state == ST_WAIT) && imem_rsp_valid && (r_kill || redirect_valid)) ||
                      ((r_state == ST_HOLD) && redirect_valid && !if_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_killed  <= '0;
    end else begin
      if (w_fetch_hs) r_perf_fetched <= r_perf_fetched + PERF_WIDTH'(1);
      if (w_drop)     r_perf_killed  <= r_perf_killed + PERF_WIDTH'(1);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_killed  = r_perf_killed;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: memory/decode driver with a PC-stream model, decoupled monitor.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC     = 32'h0000_0100;
  localparam int          N_DIRECTED = 12;
  localparam int          N_RANDOM   = 4000;
  localparam int          N_DRAIN    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .pc             (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_fetched = 0;
  int          n_killed = 0;
  int          n_presented = 0;
  int          n_acc = 0;
  logic [31:0] first_addrs [3];
  logic [31:0] model_pc;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // One cycle of memory + decode behaviour, chosen at the negedge and applied at the next posedge.
  task automatic step(input int cyc);
    bit          rv, iv, rdy, irdy, redir, fixed;
    logic [31:0] ra, tgt;
    rv    = imem_req_valid;
    ra    = imem_req_addr;
    iv    = if_valid;
    fixed = (cyc < N_DIRECTED) || (cyc >= N_DIRECTED + N_RANDOM);
    check32("pc_reg", pc, model_pc);
    if (fixed) begin
      rdy = 1'b1; irdy = 1'b1; redir = 1'b0; tgt = '0;
    end else begin
      rdy   = ($urandom_range(0, 99) < 60);
      irdy  = ($urandom_range(0, 99) < 50);
      redir = ($urandom_range(0, 99) < 8);
      tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
    end

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end
    end

    if (rv && rdy) begin
      check32("single_outstanding", 32'(mem_busy), 32'd0);
      check32("req_addr", ra, model_pc);
      if (n_acc < 3) first_addrs[n_acc] = ra;
      n_acc++;
      exp_q.push_back({ra, mem_word(ra)});
      mem_busy = 1'b1;
      mem_addr = ra;
      mem_cnt  = fixed ? 1 : $urandom_range(1, 3);
    end

    if (iv && irdy) n_fetched++;
    // A redirect kills whatever has not reached decode yet; the fetch stream restarts at the target.
    if (redir) begin
      n_killed += exp_q.size();
      exp_q.delete();
      if (iv && !irdy) n_killed++;
      model_pc = tgt;
    end else if (iv && irdy) begin
      model_pc = model_pc + 32'd4;
    end

    imem_req_ready = rdy;
    if_ready       = irdy;
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;
  endtask

  // Monitor: pops an expectation each time an instruction is newly presented.
  initial begin : monitor
    bit   prev_v;
    bit   seen_first;
    int   edges;
    exp_t cur;
    prev_v = 1'b0; seen_first = 1'b0; edges = 0; cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_v = 1'b0; seen_first = 1'b0; edges = 0;
      end else begin
        edges++;
        check32("req_and_if_valid", 32'(imem_req_valid && if_valid), 32'd0);
        if (prev_v) begin
          if (if_ready || redirect_valid) begin
            check32("if_valid_drop", 32'(if_valid), 32'd0);
          end else begin
            check32("hold_valid", 32'(if_valid), 32'd1);
            check32("hold_pc", if_pc, cur.pc);
            check32("hold_instr", if_instr, cur.instr);
          end
        end else if (if_valid) begin
          n_presented++;
          // IDLE bubble, REQ, WAIT: the first instruction shows after the third edge out of reset.
          if (!seen_first) begin
            check32("first_valid_latency", 32'(edges), 32'd3);
            seen_first = 1'b1;
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr: got pc 0x%08h, expected no presentation", if_pc);
          end else begin
            cur = exp_q.pop_front();
            check32("if_pc", if_pc, cur.pc);
            check32("if_instr", if_instr, cur.instr);
          end
        end
        prev_v = if_valid;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0ABC;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    model_pc       = RST_PC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_if_valid", 32'(if_valid), 32'd0);
    check32("rst_if_pc", if_pc, 32'd0);
    check32("rst_if_instr", if_instr, 32'd0);
    check32("rst_pc", pc, RST_PC);
    reset = 1'b0;
    for (int cyc = 0; cyc < N_DIRECTED + N_RANDOM + N_DRAIN; cyc++) begin
      if (cyc > 0) @(negedge clk);
      step(cyc);
    end
    @(posedge clk);
    #2;
    check32("first_addr0", first_addrs[0], 32'h0000_0100);
    check32("first_addr1", first_addrs[1], 32'h0000_0104);
    check32("first_addr2", first_addrs[2], 32'h0000_0108);
    check32("progress", 32'(n_presented >= 50), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check32("perf_fetched", perf_fetched, 32'(n_fetched));
    check32("perf_killed", perf_killed, 32'(n_killed));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
